// File: rtl/buffer_pkgs.sv
// Shared buffer/queue entry types for the issue-side micro-op buffers.
package buffer_pkgs;

  typedef struct packed {
    logic       valid;
    logic [6:0] rs1_tag;
    logic       rs1_rdy;
    logic [6:0] rs2_tag;
    logic       rs2_rdy;
    logic [6:0] rd_tag;
    logic [7:0] uop_id;
  } rs_entry_t;

endpackage

// File: rtl/age_ordered_rs_if.sv
// Dispatch, wakeup and issue signals of the age-ordered reservation station.
interface age_ordered_rs_if #(
  parameter type RS_ENTRY_T = buffer_pkgs::rs_entry_t,
  parameter int  RS_DEPTH   = 8,
  parameter int  NUM_CDB    = 2,
  parameter int  PREG_W     = 7
);
  logic                               recover_i;
  logic                               disp_valid_i;
  logic                               disp_ready_o;
  RS_ENTRY_T                          disp_entry_i;
  logic                               issue_valid_o;
  logic                               issue_ready_i;
  RS_ENTRY_T                          issue_entry_o;
  logic [NUM_CDB-1:0]                 cdb_valid_i;
  logic [NUM_CDB*PREG_W-1:0]          cdb_tag_i;
  logic [$clog2(RS_DEPTH+1)-1:0]      count_o;

  modport master (
    output recover_i, disp_valid_i, disp_entry_i, issue_ready_i, cdb_valid_i, cdb_tag_i,
    input  disp_ready_o, issue_valid_o, issue_entry_o, count_o
  );

  modport slave (
    input  recover_i, disp_valid_i, disp_entry_i, issue_ready_i, cdb_valid_i, cdb_tag_i,
    output disp_ready_o, issue_valid_o, issue_entry_o, count_o
  );
endinterface

// File: rtl/age_ordered_rs.sv
// Age-matrix reservation station: issues the oldest ready micro-op through a registered stage.
// Dispatch-to-issue 2 cycles; output holds while issue_ready_i=0, dispatch stalls when full.
module age_ordered_rs #(
  parameter type RS_ENTRY_T = buffer_pkgs::rs_entry_t,
  parameter int  RS_DEPTH   = 8,
  parameter int  NUM_CDB    = 2,
  parameter int  PREG_W     = 7
) (
  input  logic                clk_i,
  input  logic                rst_i,
  age_ordered_rs_if.slave     rs_if
);
  localparam int CNT_W = $clog2(RS_DEPTH + 1);
  localparam int IDX_W = $clog2(RS_DEPTH);

  RS_ENTRY_T           ent_q [RS_DEPTH];
  RS_ENTRY_T           ent_d [RS_DEPTH];
  logic [RS_DEPTH-1:0] age_q [RS_DEPTH];
  logic [RS_DEPTH-1:0] age_d [RS_DEPTH];
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_vld_q, out_vld_d;
  RS_ENTRY_T           out_ent_q, out_ent_d;

  logic [RS_DEPTH-1:0] vld_vec, rdy_vec, cand_vec;
  logic                cand_any;
  logic [IDX_W-1:0]    cand_idx, free_idx;
  logic                disp_rdy, disp_fire, load_en;
  RS_ENTRY_T           disp_ent;

  function automatic logic cdb_hit(input logic [PREG_W-1:0]         tag,
                                   input logic [NUM_CDB-1:0]        vld,
                                   input logic [NUM_CDB*PREG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (vld[p] && (tags[p*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    vld_vec  = '0;
    rdy_vec  = '0;
    cand_vec = '0;
    cand_idx = '0;
    free_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      vld_vec[i] = ent_q[i].valid;
      rdy_vec[i] = ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
    end
    // An entry is the candidate when no other ready entry is older than it.
    for (int i = 0; i < RS_DEPTH; i++) begin
      logic older;
      older = 1'b0;
      for (int j = 0; j < RS_DEPTH; j++) older = older | (rdy_vec[j] & age_q[j][i]);
      cand_vec[i] = rdy_vec[i] & ~older;
    end
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (cand_vec[i]) cand_idx = cand_idx | IDX_W'(i);
    end
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!vld_vec[i]) free_idx = IDX_W'(i);
    end
    cand_any = |cand_vec;
  end

  assign disp_rdy  = (cnt_q < CNT_W'(RS_DEPTH)) && !rs_if.recover_i;
  assign disp_fire = rs_if.disp_valid_i && disp_rdy;
  assign load_en   = cand_any && (!out_vld_q || rs_if.issue_ready_i) && !rs_if.recover_i;

  always_comb begin
    disp_ent         = rs_if.disp_entry_i;
    disp_ent.valid   = 1'b1;
    disp_ent.rs1_rdy = rs_if.disp_entry_i.rs1_rdy || (rs_if.disp_entry_i.rs1_tag == '0) ||
                       cdb_hit(rs_if.disp_entry_i.rs1_tag, rs_if.cdb_valid_i, rs_if.cdb_tag_i);
    disp_ent.rs2_rdy = rs_if.disp_entry_i.rs2_rdy || (rs_if.disp_entry_i.rs2_tag == '0) ||
                       cdb_hit(rs_if.disp_entry_i.rs2_tag, rs_if.cdb_valid_i, rs_if.cdb_tag_i);
  end

  always_comb begin
    ent_d     = ent_q;
    age_d     = age_q;
    out_vld_d = out_vld_q;
    out_ent_d = out_ent_q;
    cnt_d     = cnt_q + CNT_W'(disp_fire) - CNT_W'(load_en);

    for (int i = 0; i < RS_DEPTH; i++) begin
      if (ent_q[i].valid) begin
        if (cdb_hit(ent_q[i].rs1_tag, rs_if.cdb_valid_i, rs_if.cdb_tag_i)) ent_d[i].rs1_rdy = 1'b1;
        if (cdb_hit(ent_q[i].rs2_tag, rs_if.cdb_valid_i, rs_if.cdb_tag_i)) ent_d[i].rs2_rdy = 1'b1;
      end
    end

    if (load_en) begin
      out_vld_d        = 1'b1;
      out_ent_d        = ent_q[cand_idx];
      ent_d[cand_idx]  = '0;
      age_d[cand_idx]  = '0;
      for (int j = 0; j < RS_DEPTH; j++) age_d[j][cand_idx] = 1'b0;
    end else if (out_vld_q && rs_if.issue_ready_i) begin
      out_vld_d = 1'b0;
      out_ent_d = '0;
    end

    // free_idx is never the slot being loaded, so the two updates cannot collide.
    if (disp_fire) begin
      ent_d[free_idx] = disp_ent;
      for (int j = 0; j < RS_DEPTH; j++) begin
        age_d[j][free_idx] = vld_vec[j] && !(load_en && (cand_idx == IDX_W'(j)));
      end
      age_d[free_idx] = '0;
    end

    if (rs_if.recover_i) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_d[i] = '0;
        age_d[i] = '0;
      end
      cnt_d     = '0;
      out_vld_d = 1'b0;
      out_ent_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_q[i] <= '0;
        age_q[i] <= '0;
      end
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      out_ent_q <= '0;
    end else begin
      ent_q     <= ent_d;
      age_q     <= age_d;
      cnt_q     <= cnt_d;
      out_vld_q <= out_vld_d;
      out_ent_q <= out_ent_d;
    end
  end

  assign rs_if.disp_ready_o  = disp_rdy;
  assign rs_if.issue_valid_o = out_vld_q && !rs_if.recover_i;
  assign rs_if.issue_entry_o = rs_if.issue_valid_o ? out_ent_q : '0;
  assign rs_if.count_o       = cnt_q;
endmodule

// File: doc/age_ordered_rs.md
# age_ordered_rs

Parametrised out-of-order reservation station for one functional-unit issue port, sitting between dispatch/rename and the execution unit. Buffers up to RS_DEPTH renamed micro-ops, wakes source operands from NUM_CDB broadcast ports, and always issues the oldest ready entry through a registered, backpressure-safe output stage. Global recovery flushes all state in one cycle.

## Interface
- RS_ENTRY_T, rs_entry_t: entry type from buffer_pkgs; must contain valid, rs1_tag, rs1_rdy, rs2_tag, rs2_rdy.
- RS_DEPTH, 8: entry count, ≥2, need not be a power of two.
- NUM_CDB, 2: number of wakeup broadcast ports, ≥1.
- PREG_W, 7: physical tag width.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- recover_i  in  1  synchronous flush of all entries and the output stage.
- disp_valid_i  in  1  dispatch request.
- disp_ready_o  out  1  RS can accept an entry this cycle.
- disp_entry_i  in  RS_ENTRY_T  dispatched micro-op.
- issue_valid_o  out  1  output stage holds an entry.
- issue_ready_i  in  1  functional unit accepts.
- issue_entry_o  out  RS_ENTRY_T  issued entry; all-zero when issue_valid_o=0.
- cdb_valid_i  in  NUM_CDB  per-port wakeup valid.
- cdb_tag_i  in  NUM_CDB*PREG_W  port p tag at bits [p*PREG_W +: PREG_W].
- count_o  out  $clog2(RS_DEPTH+1)  occupied entries, excluding output stage.

## Operation
- Storage: RS_DEPTH entries plus RS_DEPTH×RS_DEPTH age matrix; age[i][j]=1 means entry i older than entry j.
- Dispatch: disp_ready_o = (count_o < RS_DEPTH) && !recover_i, from registered state only; a slot freed this cycle is not reusable until next cycle. On disp_valid_i && disp_ready_o, write lowest-index free slot k, set valid; set age[j][k]=1 for every valid j, clear row k.
- Dispatch-time readiness: source rdy forced 1 if tag==0, or if any cdb_valid_i[p] with cdb_tag_i[p] equals that source tag in the same cycle (bypass); otherwise disp_entry_i rdy bit kept.
- Wakeup: each cycle, for every valid entry and each source with rdy=0, set rdy=1 if tag matches any valid CDB port. Multiple ports matching the same tag is legal and idempotent.
- Select: ready[i] = valid & rs1_rdy & rs2_rdy. Candidate = ready i with no ready j where age[j][i]=1 (exactly one oldest).
- Output stage load: when candidate exists and (!issue_valid_o || issue_ready_i) and !recover_i, copy candidate to output register, clear its valid, rdy bits and age row/column in the same edge. Output register value is stable while issue_valid_o && !issue_ready_i.
- Accept: issue_valid_o && issue_ready_i empties stage unless reloaded the same edge (back-to-back throughput 1/cycle).
- Simultaneous dispatch and load: dispatched slot is a currently free slot; never collides with the slot being freed.
- count_o: +1 on dispatch, −1 on load, unchanged when both.
- Recover: next edge clears all valid bits, age matrix, count_o, output stage. issue_valid_o and disp_ready_o forced 0 combinationally while recover_i=1; dispatch and load in that cycle are discarded.

## Timing
- Reset values: issue_valid_o=0, issue_entry_o=0, disp_ready_o=1 after reset deasserts, count_o=0; all entries invalid, age matrix zero.
- Dispatch of fully ready entry in cycle N into empty RS: selectable N+1, issue_valid_o=1 in N+2.
- CDB wakeup in cycle N of a waiting entry: selectable N+1, issue_valid_o N+2 (if stage free).
- Full: count_o=RS_DEPTH ⇒ disp_ready_o=0; an entry loaded into the output stage in cycle N re-enables dispatch in N+1.
- Empty: no candidate ⇒ output stage not loaded; issue_entry_o returns to zero after accept.
- Reset mid-operation: asynchronous, all state cleared immediately regardless of handshakes.

## Test plan
- Dispatch A(tags 0,0), stall issue_ready_i=0 for 5 cycles -> issue_valid_o=1 from cycle 2, issue_entry_o==A constant, count_o=0; accept at cycle 7 -> issue_valid_o=0 cycle 8.
- Dispatch B(rs1_tag=5), C(rs1_tag=6), then cdb port1 tag 6, later port0 tag 5 -> C issues first, B two cycles after tag 5.
- Dispatch D(tag 9) into slot 3 then E(tag 9) into slot 0; broadcast 9 once -> D (older) issues before E despite higher index.
- Fill 8 entries, hold issue_ready_i=1 and disp_valid_i=1 with all-ready entries -> one issue per cycle, disp_ready_o never drops once steady, count_o stays 7.
- Dispatch F(rs2_tag=12) same cycle as cdb tag 12 -> F issues two cycles later (bypass honoured).
- Fill 5 entries, stage loaded, assert recover_i one cycle -> issue_valid_o=0 that cycle, count_o=0 next, no later issue until new dispatch.
